// File: rtl/motor_step_seq.sv
// motor_step_seq: commits a (motor, value) target on each falling edge of lock
// and generates step/dir pulses that move one of six motors to its target.
// Params : STEP_DIV cycles per step period, PULSE_W cycles step_out is high.
// Inputs : clk, rst_n (sync, active-low), value[9:0], motor[2:0], lock (async).
// Outputs: step_out[5:0] one-hot pulses, dir_out[5:0] (1 = position increases),
//          busy (move in progress), done (1-cycle end-of-move pulse),
//          cur_pos[9:0] position of the motor selected by the synced motor input.
// Option : define MOTOR_STEP_RAMP_EN to run the first/last 4 steps at 2x period.
module motor_step_seq #(
  parameter int STEP_DIV = 50000,
  parameter int PULSE_W  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] value,
  input  logic [2:0] motor,
  input  logic       lock,
  output logic [5:0] step_out,
  output logic [5:0] dir_out,
  output logic       busy,
  output logic       done,
  output logic [9:0] cur_pos
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, HIGH, LOW, FIN
  } state_t;

  localparam int CW = $clog2(2 * STEP_DIV + 1);
  localparam logic [CW-1:0] HI_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] LO_LAST = CW'(STEP_DIV - PULSE_W - 1);
`ifdef MOTOR_STEP_RAMP_EN
  localparam logic [CW-1:0] LO_SLOW = CW'(2 * STEP_DIV - PULSE_W - 1);
`endif

  state_t state, nxt;

  logic [9:0] val_s1, val_s2;
  logic [2:0] mot_s1, mot_s2;
  logic       lock_s1, lock_s2, lock_s3;
  logic       commit_q;

  logic       cmd_ok;
  logic [9:0] cmd_tgt;

  logic       act_v, pend_v, xfer;
  logic [2:0] act_m, pend_m;
  logic [9:0] act_tgt, pend_tgt;

  logic [9:0] pos [6];
  logic [9:0] m_pos;
  logic       up, up_w;
  logic [CW-1:0] cnt, lo_last;

`ifdef MOTOR_STEP_RAMP_EN
  logic [9:0] n_tot, n_done;
  logic       slow;
`endif

  // value/motor are taken one cycle after the lock edge is seen so the
  // multi-bit bus has had an extra cycle to settle through the syncs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_s1   <= '0;
      val_s2   <= '0;
      mot_s1   <= '0;
      mot_s2   <= '0;
      lock_s1  <= 1'b0;
      lock_s2  <= 1'b0;
      lock_s3  <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      val_s1   <= value;
      val_s2   <= val_s1;
      mot_s1   <= motor;
      mot_s2   <= mot_s1;
      lock_s1  <= lock;
      lock_s2  <= lock_s1;
      lock_s3  <= lock_s2;
      commit_q <= !lock_s2 && lock_s3;
    end
  end

  assign cmd_ok  = commit_q && (mot_s2 <= 3'd5);
  assign cmd_tgt = (val_s2 > 10'd999) ? 10'd999 : val_s2;

  assign m_pos = pos[act_m];
  assign up_w  = act_tgt > m_pos;

  // pending moves to active when the current move finishes, or when
  // it was left behind by a FIN that went idle.
  assign xfer = pend_v &&
    ((state == FIN) || (state == IDLE && !act_v));

`ifdef MOTOR_STEP_RAMP_EN
  always_comb begin
    slow    = 1'b0;
    lo_last = LO_LAST;
    slow    = (n_done <= 10'd4) || ((n_tot - n_done) < 10'd4);
    if (slow) lo_last = LO_SLOW;
  end
`else
  assign lo_last = LO_LAST;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (act_v) nxt = LOAD;
      LOAD:  nxt = (act_tgt == m_pos) ? FIN : SETUP;
      SETUP: nxt = HIGH;
      HIGH:  if (cnt == HI_LAST) nxt = LOW;
      LOW:   if (cnt == lo_last)
               nxt = (m_pos == act_tgt) ? FIN : HIGH;
      FIN:   nxt = pend_v ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_v    <= 1'b0;
      act_m    <= '0;
      act_tgt  <= '0;
      pend_v   <= 1'b0;
      pend_m   <= '0;
      pend_tgt <= '0;
      up       <= 1'b0;
      cnt      <= '0;
      dir_out  <= '0;
      step_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_pos  <= '0;
      for (int i = 0; i < 6; i++) pos[i] <= '0;
`ifdef MOTOR_STEP_RAMP_EN
      n_tot    <= '0;
      n_done   <= '0;
`endif
    end else begin
      if (nxt == state && (state == HIGH || state == LOW))
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;

      if (state == LOAD && nxt == SETUP) begin
        dir_out[act_m] <= up_w;
        up             <= up_w;
`ifdef MOTOR_STEP_RAMP_EN
        n_tot  <= up_w ? (act_tgt - m_pos) : (m_pos - act_tgt);
        n_done <= '0;
`endif
      end

      if (nxt == HIGH && state != HIGH) begin
        pos[act_m] <= up ? (m_pos + 10'd1) : (m_pos - 10'd1);
`ifdef MOTOR_STEP_RAMP_EN
        n_done <= n_done + 10'd1;
`endif
      end

      if (xfer) begin
        act_v   <= 1'b1;
        act_m   <= pend_m;
        act_tgt <= pend_tgt;
        pend_v  <= 1'b0;
      end else if (state == FIN) begin
        act_v <= 1'b0;
      end

      // a commit lands after any transfer, so it is never lost
      if (cmd_ok) begin
        if (state == IDLE && !act_v && !pend_v) begin
          act_v   <= 1'b1;
          act_m   <= mot_s2;
          act_tgt <= cmd_tgt;
        end else begin
          pend_v   <= 1'b1;
          pend_m   <= mot_s2;
          pend_tgt <= cmd_tgt;
        end
      end

      step_out <= (state == HIGH) ? (6'd1 << act_m) : 6'd0;
      busy     <= state != IDLE;
      done     <= state == FIN;
      cur_pos  <= (mot_s2 <= 3'd5) ? pos[mot_s2] : 10'd0;
    end
  end

endmodule

// File: tb/tb_motor_step_seq.sv
// tb_motor_step_seq: scoreboard bench for motor_step_seq
// (STEP_DIV=8, PULSE_W=2).
module tb_motor_step_seq;

  localparam int SD = 8;
  localparam int PW = 2;
`ifdef MOTOR_STEP_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] value = '0;
  logic [2:0] motor = '0;
  logic       lock = 1'b0;
  logic [5:0] step_out, dir_out;
  logic       busy, done;
  logic [9:0] cur_pos;

  motor_step_seq #(.STEP_DIV(SD), .PULSE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .motor(motor),
    .lock(lock), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .done(done), .cur_pos(cur_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int n;
    int dir;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   mpos [6];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int period(input int n, input int k);
    return (RAMP && (k <= 4 || n - k < 4)) ? 2 * SD : SD;
  endfunction

  function automatic int lat_exp(input int n);
    int s;
    if (n == 0) return 1;
    s = 2;
    for (int k = 1; k <= n; k++) s += period(n, k);
    return s;
  endfunction

  task automatic push_exp(input int m, input int v, input bit chained);
    exp_t e;
    int t;
    if (m > 5) return;
    t = (v > 999) ? 999 : v;
    e.m   = m;
    e.n   = (t > mpos[m]) ? t - mpos[m] : mpos[m] - t;
    e.dir = (t > mpos[m]) ? 1 : 0;
    e.lat = chained ? -1 : lat_exp(e.n);
    mpos[m] = t;
    exp_q.push_back(e);
  endtask

  task automatic commit(input int m, input int v,
                        input bit chained, input bit runs);
    @(posedge clk); #1;
    value = v[9:0];
    motor = m[2:0];
    lock  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    if (runs) push_exp(m, v, chained);
    lock = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_wait", ok, 1);
  endtask

  task automatic check_pos(input int m);
    @(posedge clk); #1;
    motor = m[2:0];
    repeat (4) @(negedge clk);
    chk("cur_pos", cur_pos, mpos[m]);
  endtask

  // monitor: pulse shape, spacing, and per-move results at done
  int         cyc = 0;
  logic [5:0] prev_step = '0;
  logic       prev_busy = 1'b0;
  int         busy_t = 0;
  bit         timed = 1'b0;
  int         rise_t = -1;
  int         npul = 0;
  logic [5:0] pmask = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      prev_step = '0;
      prev_busy = 1'b0;
      timed     = 1'b0;
      rise_t    = -1;
      npul      = 0;
      pmask     = '0;
    end else begin
      if (busy && !prev_busy) begin
        busy_t = cyc;
        timed  = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
        if (step_out[i] && !prev_step[i]) begin
          chk("step_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0 && rise_t >= 0)
            chk("step_gap", cyc - rise_t, period(exp_q[0].n, npul));
          rise_t = cyc;
          npul++;
          pmask[i] = 1'b1;
        end
        if (!step_out[i] && prev_step[i])
          chk("step_width", cyc - rise_t, PW);
      end
      if (done) begin
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("n_pulses", npul, e.n);
          chk("step_mask", int'(pmask), (e.n > 0) ? (1 << e.m) : 0);
          chk("latency", timed ? cyc - busy_t : -1, e.lat);
          if (e.n > 0) chk("dir", int'(dir_out[e.m]), e.dir);
        end
        npul   = 0;
        pmask  = '0;
        rise_t = -1;
        timed  = 1'b0;
      end
      prev_step = step_out;
      prev_busy = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int ok;
    for (int i = 0; i < 6; i++) mpos[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_step", int'(step_out), 0);
    chk("rst_dir", int'(dir_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cur_pos", int'(cur_pos), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // up 5 steps, then back down 2
    commit(2, 5, 1'b0, 1'b1);
    wait_idle(200);
    check_pos(2);
    commit(2, 3, 1'b0, 1'b1);
    wait_idle(200);
    check_pos(2);

    // zero-length move
    commit(4, 0, 1'b0, 1'b1);
    wait_idle(100);
    check_pos(4);

    // pending slot is last-wins
    commit(0, 10, 1'b0, 1'b1);
    commit(1, 7, 1'b1, 1'b0);
    commit(3, 9, 1'b1, 1'b1);
    wait_idle(400);
    check_pos(0);
    check_pos(1);
    check_pos(3);

    // illegal motor index is dropped
    seen = 0;
    @(posedge clk); #1;
    value = 10'd50;
    motor = 3'd6;
    lock  = 1'b1;
    repeat (4) @(posedge clk);
    #1 lock = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("bad_motor_busy", seen, 0);

    // value clamps to 999
    commit(1, 1020, 1'b0, 1'b1);
    wait_idle(20000);
    check_pos(1);

    // reset in the middle of a pulse
    commit(5, 20, 1'b0, 1'b1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (step_out[5]) begin
        ok = 1;
        break;
      end
    end
    chk("pulse_before_rst", ok, 1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) mpos[i] = 0;
    @(negedge clk);
    chk("midrst_step", int'(step_out), 0);
    chk("midrst_dir", int'(dir_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_cur_pos", int'(cur_pos), 0);

    // lock high through reset, falling afterwards, still commits
    #1;
    value = 10'd2;
    motor = 3'd5;
    lock  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push_exp(5, 2, 1'b0);
    lock = 1'b0;
    wait_idle(200);
    check_pos(5);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/motor_step_seq.md
# motor_step_seq

Downstream consumer of the panel input stage. Watches the button-domain `value`/`motor`/`lock` triple and treats each falling edge of `lock` as a commit of a new normalized target position (0..999) for one of six motors. Keeps the current position of every motor and generates step/direction pulses that move the committed motor to its target, one move at a time, with a one-deep pending slot for a commit that arrives during a move.

## Interface
- `STEP_DIV`, 50000: clock cycles per step period; legal range is at least `PULSE_W`+2.
- `PULSE_W`, 10: clock cycles `step_out` stays high per step.
- `clk` input 1: system clock. Single clock domain.
- `rst_n` input 1: synchronous, active-low reset.
- `value` input 10: target position from the input stage. Asynchronous to `clk`.
- `motor` input 3: motor index 0..5. Asynchronous to `clk`.
- `lock` input 1: edit-mode flag from the input stage. A 1→0 transition is a commit. Asynchronous to `clk`.
- `step_out` output 6: per-motor step pulse, one-hot while high.
- `dir_out` output 6: per-motor direction. 1 means position increases.
- `busy` output 1: a move is in progress.
- `done` output 1: one-cycle pulse when a move completes.
- `cur_pos` output 10: current position of the motor selected by the synchronized `motor` input.

## Operation
- Input sync: all 14 input bits pass through a 2-flop synchronizer (s1, s2). `lock` has a third flop, s3.
- Commit detect: `lock_s2==0 && lock_s3==1`.
  - `value`/`motor` are sampled from s2 one cycle after detection, so the multi-bit bus has settled.
- Commit legality:
  - `motor` > 5: the commit is dropped.
  - `value` > 999: clamped to 999.
- Commit queueing:
  - Idle: the commit loads the active command.
  - Busy: the commit goes to the pending slot. A newer commit overwrites an older pending one (last-wins).
- Position store: six 10-bit registers `pos[0..5]`.
- FSM states:
  - IDLE → LOAD when the active command is valid.
  - LOAD: compare target with `pos[m]`.
    - If equal: go to FIN.
    - Otherwise: drive `dir_out[m]` and go to SETUP.
  - SETUP: one cycle of direction setup before the first pulse → HIGH.
  - HIGH: `step_out[m]`=1 for `PULSE_W` cycles. On entry, `pos[m]` steps ±1 → LOW.
  - LOW: `step_out[m]`=0 for `STEP_DIV`−`PULSE_W` cycles.
    - If `pos[m]`==target: go to FIN.
    - Otherwise: go to HIGH.
  - FIN: `done`=1 for one cycle.
    - If pending is valid: move it to active and go to LOAD.
    - Otherwise: go to IDLE.
- `dir_out` bits hold their last value between moves. Only the active motor's bit ever changes.
- `busy` is high in LOAD, SETUP, HIGH, LOW and FIN.

## Timing
- Reset values:
  - `step_out`=0, `dir_out`=0, `busy`=0, `done`=0.
  - All `pos`=0, `cur_pos`=0.
  - Synchronizers = 0. Pending and active commands are invalid.
  - FSM = IDLE.
- Reset mid-move:
  - Takes effect on the next clock edge: pulse aborted, positions return to 0.
  - A `lock` that is high through reset and falls afterwards still commits.
- Commit latency: `lock` falls → command is active 4 clocks later → LOAD on the next clock.
- First `step_out` rise: 3 cycles after LOAD is entered (LOAD, SETUP, first HIGH cycle).
- Move duration:
  - A move of N steps from LOAD to the `done` pulse takes 2 + N×`STEP_DIV` + 1 cycles.
  - A zero-length move gives `done` 2 cycles after LOAD.
- `cur_pos` is registered: 1-cycle lag after a `pos` update or a change of `motor_s2`.
- Commit in the same cycle as FIN: it goes to pending and is served after the current pending. The slot is written after the pending→active transfer.

## Configuration
- `MOTOR_STEP_RAMP_EN` defined:
  - The first 4 and last 4 steps of a move use a period of 2×`STEP_DIV`. The LOW phase is extended; HIGH is unchanged.
  - Moves shorter than 8 steps use the doubled period for every step.
  - Move-duration formula: each slowed step adds `STEP_DIV` cycles.
- Undefined: every step uses `STEP_DIV`. No ramp counter logic is present.

## Test plan
Benches use `STEP_DIV`=8 and `PULSE_W`=2.
- Reset, then commit motor=2, value=5 → exactly 5 pulses on `step_out[2]`, each 2 cycles wide, spaced 8 cycles apart. `dir_out[2]`=1. `pos[2]`=5. `done` pulses once, 43 cycles after LOAD.
- Then commit motor=2, value=3 → 2 pulses with `dir_out[2]`=0. `cur_pos` reads 3 with motor=2.
- Commit motor=4, value=0 while `pos[4]`=0 → no pulses, `done` 2 cycles after LOAD.
- During a motor 0 move to 10, commit motor 1→7 and then motor 3→9 → motor 0 completes. Only motor 3 then moves (9 pulses). `pos[1]` stays 0.
- Commit motor=6 value=50, and separately motor=1 value=1020 → the first is ignored (`busy` stays 0). The second moves motor 1 to 999.
- Assert `rst_n`=0 mid-pulse → the next cycle has all outputs 0 and `pos` 0. With the ramp macro, a 10-step move shows steps 1–4 and 7–10 at 16-cycle spacing and steps 5–6 at 8-cycle spacing.
